ysyx_25040109_ifu: RTL and testbench
====================================

Name: ysyx_25040109_ifu

Overview:
Instruction fetch unit for the multicycle NPC. It is the producer end of the instruction interface consumed by the decode stage.
- Holds the PC and issues one AXI4-Lite read per instruction.
- Presents the returned word plus its PC to decode through a valid/ready handshake.
- Waits for the retiring instruction's next PC before starting the next fetch.

Parameters:
RESET_PC, 32'h8000_0000, PC loaded on reset.
ADDR_W, 32, address and PC width.

Ports:
clk  in  1  clock; all logic is rising-edge.
rst  in  1  reset; synchronous, active-high.
araddr  out  ADDR_W  AXI AR address.
arvalid  out  1  AXI AR valid.
arready  in  1  AXI AR ready.
rdata  in  32  AXI R data.
rresp  in  2  AXI R response.
rvalid  in  1  AXI R valid.
rready  out  1  AXI R ready.
inst  out  32  fetched instruction to decode.
pc  out  ADDR_W  PC of inst.
inst_valid  out  1  inst/pc/fetch_fault valid.
inst_ready  in  1  decode accepts.
fetch_fault  out  1  access fault on this fetch (bus error or misaligned PC).
upd_valid  in  1  retire strobe from write-back.
next_pc  in  ADDR_W  PC of the next instruction, qualified by upd_valid.

Behaviour:
Reset values while rst=1:
- pc=RESET_PC, state=S_AR.
- arvalid=0, rready=0, inst_valid=0, inst=0, fetch_fault=0.
- araddr is don't-care but is driven as pc.

States:
- S_AR:
  - If pc[1:0]!=0: no bus request. inst=0, fetch_fault=1, go to S_OUT next cycle.
  - Otherwise arvalid=1, araddr=pc. Go to S_R on arvalid&&arready.
  - arvalid is asserted from the first cycle after rst deasserts and stays high until the handshake (AXI stability rule).
  - araddr is stable while arvalid=1.
- S_R:
  - rready=1. On rvalid capture rdata into inst.
  - fetch_fault=(rresp!=2'b00). On fault, inst is forced to 0 so decode flags it invalid.
  - Go to S_OUT.
- S_OUT:
  - inst_valid=1. inst, pc and fetch_fault are held stable.
  - On inst_ready go to S_WAIT; inst_valid drops the next cycle.
- S_WAIT:
  - On upd_valid: pc<=next_pc, go to S_AR.

Rules:
- Latency with an ideal slave (arready=1 at once, rvalid one cycle after the AR handshake): arvalid rises in cycle 0, inst_valid rises in cycle 2.
- Only one outstanding read at a time. arvalid and rready are never high together.
- upd_valid outside S_WAIT is ignored. A simulation assertion fires in that case.
- An R beat arriving in any state other than S_R is a protocol error. Simulation asserts; the RTL ignores it.
- rst during any state aborts immediately and returns to the reset values. The slave is reset on the same rst, so no stale R beat is expected.
- next_pc is taken as-is. Misalignment is detected on the following S_AR.
- The PC update is a plain register load; no arithmetic happens in this block.

Optional Feature:
Macro: YSYX_25040109_IFU_PERF_EN.
- Defined:
  - Extra outputs perf_fetch_cnt[63:0] (incremented on each inst_valid&&inst_ready) and perf_fetch_cyc[63:0] (incremented every cycle the state is S_AR or S_R).
  - Both clear on rst and wrap modulo 2^64.
- Undefined: the ports and counters are absent; functionality is otherwise identical.

Decomposition:
- Package ysyx_25040109_pkg holds:
  - the IFU state encoding: S_AR, S_R, S_OUT, S_WAIT (2 bits);
  - AXI response constants: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - RESET_PC default.
- No sub-module: the FSM, PC register and perf counters stay inline.

Test Plan:
1. Reset then ideal slave returning 32'h00000413 → araddr=0x80000000, inst_valid high two cycles after arvalid, inst=0x00000413, pc=0x80000000, fetch_fault=0.
2. Slave holds arready=0 for 5 cycles and rvalid 3 cycles late → arvalid and araddr stable throughout, exactly one AR handshake, inst correct.
3. inst_ready=0 for 4 cycles → inst_valid, inst and pc held; then upd_valid with next_pc=0x80000004 → next araddr=0x80000004.
4. rresp=2'b10 with rdata=0xDEADBEEF → inst=0, fetch_fault=1, inst_valid=1.
5. next_pc=0x80000002 → no arvalid, fetch_fault=1 delivered next cycle with pc=0x80000002.
6. rst asserted in S_R for one cycle → rready=0 and inst_valid=0 on the next edge; the fetch restarts at 0x80000000. upd_valid pulsed in S_OUT → ignored and the assertion fires.

Source files
------------

// File: rtl/ysyx_25040109_pkg.sv
// Shared definitions for the NPC instruction fetch unit: FSM encoding,
// AXI response codes and the default reset PC.
package ysyx_25040109_pkg;

  typedef enum logic [1:0] {
    S_AR   = 2'd0,
    S_R    = 2'd1,
    S_OUT  = 2'd2,
    S_WAIT = 2'd3
  } ifu_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25040109_ifu.sv
// Multicycle instruction fetch: one AXI4-Lite read per instruction, handed to decode
// via valid/ready, then parked until write-back supplies the next PC.
// Optional perf counters under YSYX_25040109_IFU_PERF_EN.
module ysyx_25040109_ifu
  import ysyx_25040109_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              fetch_fault,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] next_pc
`ifdef YSYX_25040109_IFU_PERF_EN
  ,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_fetch_cyc
`endif
);

  ifu_state_e state;

  // pc only changes in S_WAIT, so araddr is inherently stable while arvalid is up
  assign araddr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_AR;
      pc          <= RESET_PC;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      inst_valid  <= 1'b0;
      inst        <= '0;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        S_AR: begin
          if (!arvalid) begin
            if (pc[1:0] != 2'b00) begin
              inst        <= '0;
              fetch_fault <= 1'b1;
              inst_valid  <= 1'b1;
              state       <= S_OUT;
            end else begin
              arvalid     <= 1'b1;
              fetch_fault <= 1'b0;
            end
          end else if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_R;
          end
        end
        S_R: begin
          if (rvalid) begin
            rready      <= 1'b0;
            inst_valid  <= 1'b1;
            fetch_fault <= (rresp != RESP_OKAY);
            // faulted fetches hand decode an all-zero word so it reads as illegal
            inst        <= (rresp == RESP_OKAY) ? rdata : '0;
            state       <= S_OUT;
          end
        end
        S_OUT: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (upd_valid) begin
            pc    <= next_pc;
            state <= S_AR;
          end
        end
        default: state <= S_AR;
      endcase
    end
  end

`ifdef YSYX_25040109_IFU_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_fetch_cyc <= '0;
    end else begin
      if (inst_valid && inst_ready)
        perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (state == S_AR || state == S_R)
        perf_fetch_cyc <= perf_fetch_cyc + 64'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // A stray retire is tolerated by the datapath, so it only warns.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(upd_valid && state != S_WAIT))
        else $warning("ifu: upd_valid outside S_WAIT ignored");
      assert (!(rvalid && state != S_R))
        else $error("ifu: R beat outside S_R");
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_25040109_ifu.sv
// Directed + randomized bench for ysyx_25040109_ifu with a transaction-level slave/model.
module tb_ysyx_25040109_ifu;
  import ysyx_25040109_pkg::*;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] RPC    = 32'h8000_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready = 1'b0;
  logic [31:0]       rdata = '0;
  logic [1:0]        rresp = '0;
  logic              rvalid = 1'b0;
  logic              rready;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] pc;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic              fetch_fault;
  logic              upd_valid = 1'b0;
  logic [ADDR_W-1:0] next_pc = '0;
`ifdef YSYX_25040109_IFU_PERF_EN
  logic [63:0]       perf_fetch_cnt, perf_fetch_cyc;
`endif

  ysyx_25040109_ifu #(.ADDR_W(ADDR_W), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .pc(pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .fetch_fault(fetch_fault), .upd_valid(upd_valid), .next_pc(next_pc)
`ifdef YSYX_25040109_IFU_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_fetch_cyc(perf_fetch_cyc)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  int overlap = 0;
  logic [31:0] model_pc;

  // bus monitors: AR handshakes and illegal AR/R overlap
  always @(posedge clk) begin
    if (!rst && arvalid && arready) hs_cnt++;
    if (!rst && arvalid && rready)  overlap++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One instruction from S_AR to S_WAIT; slave timing and response chosen by caller.
  task automatic fetch(input int ar_dly, input int r_dly, input int out_dly,
                       input logic [31:0] data, input logic [1:0] resp, input bit poke_upd);
    int n;
    logic [31:0] exp_i;
    logic exp_f;
    n = 0;
    if (model_pc[1:0] != 2'b00) begin
      while (!inst_valid && n < 5) begin
        chk("misalign_no_ar", arvalid, 0);
        tick; n++;
      end
      chk("misalign_latency", n, 1);
      exp_i = '0;
      exp_f = 1'b1;
    end else begin
      while (!arvalid && n < 10) begin
        chk("no_early_valid", inst_valid, 0);
        tick; n++;
      end
      chk("ar_seen", arvalid, 1);
      chk("araddr", araddr, model_pc);
      chk("no_rready_in_ar", rready, 0);
      repeat (ar_dly) begin
        tick;
        chk("arvalid_hold", arvalid, 1);
        chk("araddr_hold", araddr, model_pc);
      end
      arready = 1'b1;
      tick;
      arready = 1'b0;
      chk("ar_drop", arvalid, 0);
      chk("rready", rready, 1);
      chk("valid_before_r", inst_valid, 0);
      repeat (r_dly) begin
        tick;
        chk("rready_hold", rready, 1);
        chk("valid_wait_r", inst_valid, 0);
      end
      rvalid = 1'b1; rdata = data; rresp = resp;
      tick;
      rvalid = 1'b0; rdata = $urandom; rresp = '0;
      chk("rready_drop", rready, 0);
      exp_f = (resp != RESP_OKAY);
      exp_i = exp_f ? 32'h0 : data;
    end
    chk("inst_valid", inst_valid, 1);
    chk("inst", inst, exp_i);
    chk("pc", pc, model_pc);
    chk("fetch_fault", fetch_fault, exp_f);
    for (int k = 0; k < out_dly; k++) begin
      upd_valid = poke_upd && (k == 0);
      next_pc   = $urandom;
      tick;
      upd_valid = 1'b0;
      chk("hold_valid", inst_valid, 1);
      chk("hold_inst", inst, exp_i);
      chk("hold_pc", pc, model_pc);
      chk("hold_fault", fetch_fault, exp_f);
      chk("hold_no_ar", arvalid, 0);
    end
    inst_ready = 1'b1;
    tick;
    inst_ready = 1'b0;
    chk("valid_drop", inst_valid, 0);
  endtask

  task automatic retire(input logic [31:0] npc, input int dly);
    repeat (dly) begin
      tick;
      chk("wait_idle_ar", arvalid, 0);
      chk("wait_idle_valid", inst_valid, 0);
    end
    upd_valid = 1'b1;
    next_pc   = npc;
    tick;
    upd_valid = 1'b0;
    chk("pc_load", pc, npc);
    model_pc = npc;
  endtask

  initial begin
    int hs0, n, r;
    logic [1:0] resp_tbl [6];
    logic [31:0] npc;
    resp_tbl = '{RESP_OKAY, RESP_OKAY, RESP_OKAY, RESP_SLVERR, RESP_DECERR, 2'b01};

    rst = 1'b1;
    repeat (3) tick;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_pc", pc, RPC);
    chk("rst_araddr", araddr, RPC);
    rst = 1'b0;
    model_pc = RPC;

    // ideal slave, then decode stalls 4 cycles
    fetch(0, 0, 4, 32'h0000_0413, RESP_OKAY, 1'b0);
    retire(32'h8000_0004, 1);

    // slow slave: 5 AR wait cycles, R 3 cycles late, exactly one handshake
    hs0 = hs_cnt;
    fetch(5, 3, 0, 32'h1234_5678, RESP_OKAY, 1'b0);
    chk("one_handshake", hs_cnt - hs0, 1);
    retire(32'h8000_0008, 2);

    // bus error
    fetch(1, 0, 1, 32'hDEAD_BEEF, RESP_SLVERR, 1'b0);
    retire(32'h8000_0002, 0);

    // misaligned PC: no request, fault delivered next cycle
    hs0 = hs_cnt;
    fetch(0, 0, 1, 32'h0, RESP_OKAY, 1'b0);
    chk("misalign_no_handshake", hs_cnt - hs0, 0);
    retire(32'h8000_0010, 0);

    // reset while in S_R
    n = 0;
    while (!arvalid && n < 10) begin tick; n++; end
    chk("pre_rst_ar", arvalid, 1);
    arready = 1'b1;
    tick;
    arready = 1'b0;
    chk("pre_rst_rready", rready, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_rready", rready, 0);
    chk("abort_valid", inst_valid, 0);
    chk("abort_pc", pc, RPC);
    model_pc = RPC;

    // restart at reset PC; a stray upd_valid in S_OUT must be ignored
    fetch(0, 1, 3, 32'h0010_0073, RESP_OKAY, 1'b1);
    retire(32'h8000_0004, 0);

    for (int i = 0; i < 24; i++) begin
      fetch($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
            $urandom, resp_tbl[$urandom_range(0, 5)], 1'b0);
      r = $urandom_range(0, 9);
      if (r == 0)      npc = model_pc + 32'd2;
      else if (r == 1) npc = $urandom & 32'hFFFF_FFFC;
      else             npc = (model_pc & 32'hFFFF_FFFC) + 32'd4;
      retire(npc, $urandom_range(0, 2));
    end

    chk("no_ar_r_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
